// File: rtl/switch_press_detector_if.sv
// Signal bundle between the push-button conditioner and its consumers.
// The master side drives the raw switch; the slave side returns debounced level and events.
interface switch_press_detector_if;
  logic i_Switch;
  logic o_Switch;
  logic o_Press;
  logic o_Release;

  modport master (output i_Switch, input o_Switch, o_Press, o_Release);
  modport slave  (input i_Switch, output o_Switch, o_Press, o_Release);
endinterface

// File: rtl/switch_press_detector.sv
// Push-button synchroniser, debouncer and single-cycle press/release event generator.
// Define SWITCH_PRESS_AUTO_REPEAT_EN to add hold-to-auto-repeat press events.
module switch_press_detector #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned REPEAT_DELAY   = 12500000,
  parameter int unsigned REPEAT_RATE    = 2500000
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  switch_press_detector_if.slave sw_if
);

  localparam int unsigned   DbW    = $clog2(DEBOUNCE_LIMIT);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_LIMIT - 1);

  if (DEBOUNCE_LIMIT < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("switch_press_detector: parameter out of range");
  end

  // State | meaning: IDLE | released; HELD | pressed, before first repeat; REPEAT | pressed, repeating
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef SWITCH_PRESS_AUTO_REPEAT_EN
    ST_REPEAT = 2'd2,
`endif
    ST_HELD   = 2'd1
  } state_e;

  logic           r_Sync1, r_Sync2;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           switch_q, switch_d;
  logic           press_q, press_d;
  logic           release_q, release_d;
  logic           rise, fall;
  state_e         state_q, state_d;

`ifdef SWITCH_PRESS_AUTO_REPEAT_EN
  localparam int unsigned    RepMax    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned    RepW      = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] DelayLast = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RateLast  = RepW'(REPEAT_RATE - 1);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
`endif

  // Any agreeing cycle restarts the count, so only an uninterrupted run flips the level.
  always_comb begin
    db_cnt_d = '0;
    switch_d = switch_q;
    rise     = 1'b0;
    fall     = 1'b0;
    if (r_Sync2 != switch_q) begin
      if (db_cnt_q == DbLast) begin
        switch_d = r_Sync2;
        rise     = r_Sync2;
        fall     = ~r_Sync2;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef SWITCH_PRESS_AUTO_REPEAT_EN
    rep_cnt_d = rep_cnt_q + 1'b1;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef SWITCH_PRESS_AUTO_REPEAT_EN
        rep_cnt_d = '0;
`endif
        if (rise) begin
          state_d = ST_HELD;
          press_d = 1'b1;
        end
      end
      ST_HELD: begin
        if (fall) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
`ifdef SWITCH_PRESS_AUTO_REPEAT_EN
          rep_cnt_d = '0;
        end else if (rep_cnt_q == DelayLast) begin
          state_d   = ST_REPEAT;
          press_d   = 1'b1;
          rep_cnt_d = '0;
`endif
        end
      end
`ifdef SWITCH_PRESS_AUTO_REPEAT_EN
      ST_REPEAT: begin
        if (fall) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          rep_cnt_d = '0;
        end else if (rep_cnt_q == RateLast) begin
          press_d   = 1'b1;
          rep_cnt_d = '0;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Sync1   <= 1'b0;
      r_Sync2   <= 1'b0;
      db_cnt_q  <= '0;
      switch_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      r_Sync1   <= sw_if.i_Switch;
      r_Sync2   <= r_Sync1;
      db_cnt_q  <= db_cnt_d;
      switch_q  <= switch_d;
      press_q   <= press_d;
      release_q <= release_d;
      state_q   <= state_d;
    end
  end

`ifdef SWITCH_PRESS_AUTO_REPEAT_EN
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`endif

  assign sw_if.o_Switch  = switch_q;
  assign sw_if.o_Press   = press_q;
  assign sw_if.o_Release = release_q;

endmodule
